// File: rtl/m_store_pack_if.sv
// Request/bus/exception bundle between a store producer and m_store_pack.
// The master drives store requests and bus acceptance; the slave (the packer) drives the rest.
interface m_store_pack_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_addr;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, out_ready,
        input  req_ready, out_valid, out_addr, out_data, out_be,
        input  exc_valid, exc_code, exc_addr
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, out_ready,
        output req_ready, out_valid, out_addr, out_data, out_be,
        output exc_valid, exc_code, exc_addr
    );
endinterface

// File: rtl/m_store_pack.sv
// Store packer: lane-aligns sw/sh/sb data into byte enables and queues them in a DEPTH-entry FIFO.
// Define MISALIGN_EXC_EN to trap misaligned sw/sh with AdES; otherwise they are force-aligned.
module m_store_pack #(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    m_store_pack_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SW   = 2'b01;
    localparam logic [1:0] OP_SH   = 2'b10;
    localparam logic [1:0] OP_SB   = 2'b11;

    function automatic logic [1:0] align_lsb(input logic [1:0] op, input logic [1:0] lsb);
        case (op)
            OP_SW:   align_lsb = 2'b00;
            OP_SH:   align_lsb = {lsb[1], 1'b0};
            default: align_lsb = lsb;
        endcase
    endfunction

    function automatic logic [3:0] pack_be(input logic [1:0] op, input logic [1:0] lsb);
        case (op)
            OP_SW:   pack_be = 4'b1111;
            OP_SH:   pack_be = lsb[1] ? 4'b1100 : 4'b0011;
            OP_SB:   pack_be = 4'b0001 << lsb;
            default: pack_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] pack_data(input logic [1:0] op,
                                                    input logic [DATA_W-1:0] wdata);
        case (op)
            OP_SH:   pack_data = {2{wdata[15:0]}};
            OP_SB:   pack_data = {4{wdata[7:0]}};
            default: pack_data = wdata;
        endcase
    endfunction

`ifdef MISALIGN_EXC_EN
    localparam logic [4:0] EXC_ADES = 5'd5;

    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] lsb);
        is_misaligned = ((op == OP_SW) && (lsb != 2'b00)) || ((op == OP_SH) && lsb[0]);
    endfunction
`endif

    logic              vld_p0;
    logic              mis_p0;
    logic              push_p0;
    logic [1:0]        lsb_p0;
    logic [3:0]        be_p0;
    logic [DATA_W-1:0] data_p0;

    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [PTR_W:0]    count_p1;
    logic              vld_p1;
    logic              pop_p1;

    logic [29:0]       addr_mem_p1 [DEPTH];
    logic [DATA_W-1:0] data_mem_p1 [DEPTH];
    logic [3:0]        be_mem_p1   [DEPTH];

    // Stage p0: accept and pack the incoming request
    assign vld_p0  = bus.req_valid && bus.req_ready && (bus.req_op != OP_NONE);
`ifdef MISALIGN_EXC_EN
    assign mis_p0  = is_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
    assign mis_p0  = 1'b0;
`endif
    assign lsb_p0  = align_lsb(bus.req_op, bus.req_addr[1:0]);
    assign be_p0   = pack_be(bus.req_op, lsb_p0);
    assign data_p0 = pack_data(bus.req_op, bus.req_wdata);
    assign push_p0 = vld_p0 && !mis_p0;

    // Stage p1: FIFO control; reset outranks flush, both outrank push/pop
    assign vld_p1 = (count_p1 != '0);
    assign pop_p1 = vld_p1 && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
            end
            if (pop_p1) begin
                rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
            end
            case ({push_p0, pop_p1})
                2'b10:   count_p1 <= count_p1 + 1'b1;
                2'b01:   count_p1 <= count_p1 - 1'b1;
                default: count_p1 <= count_p1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            addr_mem_p1[wr_ptr_p1] <= bus.req_addr[31:2];
            data_mem_p1[wr_ptr_p1] <= data_p0;
            be_mem_p1[wr_ptr_p1]   <= be_p0;
        end
    end

    // Outputs read zero while empty so stale storage never leaks onto the bus
    assign bus.req_ready = (count_p1 != FULL_CNT);
    assign bus.out_valid = vld_p1;
    assign bus.out_addr  = vld_p1 ? {addr_mem_p1[rd_ptr_p1], 2'b00} : '0;
    assign bus.out_data  = vld_p1 ? data_mem_p1[rd_ptr_p1] : '0;
    assign bus.out_be    = vld_p1 ? be_mem_p1[rd_ptr_p1] : '0;

`ifdef MISALIGN_EXC_EN
    logic        exc_vld_p1;
    logic [31:0] exc_addr_p1;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            exc_vld_p1 <= 1'b0;
        end else begin
            exc_vld_p1 <= vld_p0 && mis_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0 && mis_p0) begin
            exc_addr_p1 <= bus.req_addr;
        end
    end

    assign bus.exc_valid = exc_vld_p1;
    assign bus.exc_code  = exc_vld_p1 ? EXC_ADES : 5'd0;
    assign bus.exc_addr  = exc_vld_p1 ? exc_addr_p1 : '0;
`else
    assign bus.exc_valid = 1'b0;
    assign bus.exc_code  = 5'd0;
    assign bus.exc_addr  = '0;
`endif
endmodule

// File: tb/tb_m_store_pack.sv
// Bench for m_store_pack: packing table, full/misalign/flush/reset/wrap sequences, then random traffic
// compared each cycle against a queue-based reference model.
module tb_m_store_pack;
    localparam int DEPTH = 2;
`ifdef MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    m_store_pack_if bus_if ();

    m_store_pack #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    ent_t        popped[$];
    logic        m_exc_v = 1'b0;
    logic [31:0] m_exc_a = 32'd0;

    function automatic ent_t model_pack(input logic [1:0] op, input logic [31:0] addr,
                                        input logic [31:0] wdata);
        ent_t e;
        e.addr = addr & 32'hFFFF_FFFC;
        case (op)
            2'b01: begin e.be = 4'hF; e.data = wdata; end
            2'b10: begin
                e.be   = addr[1] ? 4'hC : 4'h3;
                e.data = {16'd0, wdata[15:0]} * 32'h0001_0001;
            end
            default: begin
                e.be   = 4'(1 << addr[1:0]);
                e.data = {24'd0, wdata[7:0]} * 32'h0101_0101;
            end
        endcase
        return e;
    endfunction

    function automatic logic model_mis(input logic [1:0] op, input logic [31:0] addr);
        return (op == 2'b01 && addr[1:0] != 2'b00) || (op == 2'b10 && addr[0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic ev;
        ev = (mq.size() > 0);
        chk("out_valid", 32'(bus_if.out_valid), 32'(ev));
        chk("out_addr",  bus_if.out_addr, ev ? mq[0].addr : 32'd0);
        chk("out_data",  bus_if.out_data, ev ? mq[0].data : 32'd0);
        chk("out_be",    32'(bus_if.out_be), ev ? 32'(mq[0].be) : 32'd0);
        chk("req_ready", 32'(bus_if.req_ready), 32'(mq.size() < DEPTH));
        chk("exc_valid", 32'(bus_if.exc_valid), 32'(m_exc_v));
        chk("exc_code",  32'(bus_if.exc_code), m_exc_v ? 32'd5 : 32'd0);
        chk("exc_addr",  bus_if.exc_addr, m_exc_v ? m_exc_a : 32'd0);
    endtask

    task automatic cycle(input logic rst_i, input logic fl_i, input logic v_i,
                         input logic [1:0] op_i, input logic [31:0] a_i,
                         input logic [31:0] d_i, input logic ordy_i);
        logic acc;
        logic mis;
        logic pop;
        ent_t e;
        reset            = rst_i;
        flush            = fl_i;
        bus_if.req_valid = v_i;
        bus_if.req_op    = op_i;
        bus_if.req_addr  = a_i;
        bus_if.req_wdata = d_i;
        bus_if.out_ready = ordy_i;
        acc = v_i && (mq.size() < DEPTH) && (op_i != 2'b00);
        mis = MIS_EN && model_mis(op_i, a_i);
        pop = (mq.size() > 0) && ordy_i;
        if (!rst_i && !fl_i && bus_if.out_valid && ordy_i) begin
            e.addr = bus_if.out_addr;
            e.data = bus_if.out_data;
            e.be   = bus_if.out_be;
            popped.push_back(e);
        end
        @(posedge clk);
        if (rst_i || fl_i) begin
            mq.delete();
            m_exc_v = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc && !mis) mq.push_back(model_pack(op_i, a_i, d_i));
            m_exc_v = acc && mis;
            if (acc && mis) m_exc_a = a_i;
        end
        #1;
        compare_model();
    endtask

    task automatic idle(input logic ordy_i);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, ordy_i);
    endtask

    task automatic push(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] d_i);
        cycle(1'b0, 1'b0, 1'b1, op_i, a_i, d_i, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    endtask

    vec_t        vecs[8];
    logic [31:0] wr_addr[10];
    logic [31:0] wr_data[10];

    initial begin
        vecs[0] = '{2'b11, 32'h0000_1003, 32'h1234_56AB, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
        vecs[1] = '{2'b11, 32'h0000_2000, 32'hFFFF_FF01, 1'b1, 32'h0000_2000, 4'b0001, 32'h0101_0101};
        vecs[2] = '{2'b10, 32'h0000_3002, 32'hDEAD_BEEF, 1'b1, 32'h0000_3000, 4'b1100, 32'hBEEF_BEEF};
        vecs[3] = '{2'b10, 32'h0000_4000, 32'h0000_CAFE, 1'b1, 32'h0000_4000, 4'b0011, 32'hCAFE_CAFE};
        vecs[4] = '{2'b01, 32'h0000_5004, 32'h89AB_CDEF, 1'b1, 32'h0000_5004, 4'b1111, 32'h89AB_CDEF};
        vecs[5] = '{2'b11, 32'h0000_6001, 32'h0000_0077, 1'b1, 32'h0000_6000, 4'b0010, 32'h7777_7777};
        vecs[6] = '{2'b11, 32'h7FFF_FFFE, 32'h0000_005A, 1'b1, 32'h7FFF_FFFC, 4'b0100, 32'h5A5A_5A5A};
        vecs[7] = '{2'b00, 32'h0000_0100, 32'h1111_1111, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000};

        // reset state
        do_reset();
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_out_addr", bus_if.out_addr, 32'd0);
        chk("rst_out_be", 32'(bus_if.out_be), 32'd0);
        chk("rst_exc_valid", 32'(bus_if.exc_valid), 32'd0);

        // packing table
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            chk("tbl_valid", 32'(bus_if.out_valid), 32'(vecs[i].exp_valid));
            chk("tbl_addr", bus_if.out_addr, vecs[i].exp_addr);
            chk("tbl_be", 32'(bus_if.out_be), 32'(vecs[i].exp_be));
            chk("tbl_data", bus_if.out_data, vecs[i].exp_data);
            idle(1'b1);
        end

        // full, stall, pop, then simultaneous push/pop
        do_reset();
        push(2'b01, 32'h10, 32'h1111_1111);
        push(2'b10, 32'h16, 32'hAAAA_2222);
        chk("full_ready", 32'(bus_if.req_ready), 32'd0);
        chk("full_addr", bus_if.out_addr, 32'h10);
        chk("full_be", 32'(bus_if.out_be), 32'hF);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'h18, 32'h0000_3333, 1'b0);
        chk("stall_addr", bus_if.out_addr, 32'h10);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'h18, 32'h0000_3333, 1'b1);
        chk("pop1_addr", bus_if.out_addr, 32'h14);
        chk("pop1_be", 32'(bus_if.out_be), 32'hC);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'h18, 32'h0000_3333, 1'b1);
        chk("pushpop_addr", bus_if.out_addr, 32'h18);
        chk("pushpop_data", bus_if.out_data, 32'h3333_3333);
        chk("pushpop_ready", 32'(bus_if.req_ready), 32'd1);
        idle(1'b1);

        // misaligned sw
        do_reset();
        push(2'b01, 32'h0000_2002, 32'hCAFE_F00D);
`ifdef MISALIGN_EXC_EN
        chk("mis_exc_valid", 32'(bus_if.exc_valid), 32'd1);
        chk("mis_exc_code", 32'(bus_if.exc_code), 32'd5);
        chk("mis_exc_addr", bus_if.exc_addr, 32'h0000_2002);
        chk("mis_out_valid", 32'(bus_if.out_valid), 32'd0);
        idle(1'b0);
        chk("mis_exc_pulse", 32'(bus_if.exc_valid), 32'd0);
`else
        chk("mis_out_addr", bus_if.out_addr, 32'h0000_2000);
        chk("mis_out_be", 32'(bus_if.out_be), 32'hF);
        chk("mis_out_data", bus_if.out_data, 32'hCAFE_F00D);
        chk("mis_exc_valid", 32'(bus_if.exc_valid), 32'd0);
`endif
        idle(1'b1);

        // flush with a same-cycle push
        do_reset();
        push(2'b01, 32'h30, 32'h3030_3030);
        push(2'b01, 32'h34, 32'h3434_3434);
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 32'h38, 32'h3838_3838, 1'b0);
        chk("flush_valid", 32'(bus_if.out_valid), 32'd0);
        chk("flush_ready", 32'(bus_if.req_ready), 32'd1);
        idle(1'b1);
        chk("flush_dropped", 32'(bus_if.out_valid), 32'd0);

        // reset mid-operation with an entry buffered and an exception pending
        do_reset();
        push(2'b01, 32'h40, 32'h4040_4040);
        push(2'b10, 32'h45, 32'h0000_4545);
        cycle(1'b1, 1'b1, 1'b1, 2'b01, 32'h48, 32'h4848_4848, 1'b1);
        chk("midrst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("midrst_addr", bus_if.out_addr, 32'd0);
        chk("midrst_data", bus_if.out_data, 32'd0);
        chk("midrst_be", 32'(bus_if.out_be), 32'd0);
        chk("midrst_exc", 32'(bus_if.exc_valid), 32'd0);
        chk("midrst_exc_addr", bus_if.exc_addr, 32'd0);
        chk("midrst_ready", 32'(bus_if.req_ready), 32'd1);

        // wrap-around: 10 sh stores, out_ready toggling
        do_reset();
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            wr_addr[i] = 32'h100 + 32'(2 * i);
            wr_data[i] = $urandom;
        end
        begin
            int idx;
            int cyc;
            logic ordy;
            idx = 0;
            cyc = 0;
            while (cyc < 80 && (idx < 10 || mq.size() > 0)) begin
                ordy = cyc[0];
                if (idx < 10) begin
                    logic will_acc;
                    will_acc = (mq.size() < DEPTH);
                    cycle(1'b0, 1'b0, 1'b1, 2'b10, wr_addr[idx], wr_data[idx], ordy);
                    if (will_acc) idx++;
                end else begin
                    idle(ordy);
                end
                cyc++;
            end
        end
        chk("wrap_count", 32'(popped.size()), 32'd10);
        for (int k = 0; k < 10 && k < popped.size(); k++) begin
            chk("wrap_addr", popped[k].addr, wr_addr[k] & 32'hFFFF_FFFC);
            chk("wrap_data", popped[k].data, {wr_data[k][15:0], wr_data[k][15:0]});
            chk("wrap_be", 32'(popped[k].be), wr_addr[k][1] ? 32'hC : 32'h3);
        end

        // random traffic against the reference model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            cycle(r == 0, (r == 1) || (r == 2), $urandom_range(0, 3) != 0, 2'($urandom),
                  $urandom, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
